// File: rtl/slu_regfile_sync_if.sv
// SLU access bus plus register-image outputs of slu_regfile_sync.
// data_bus is a plain inout port on the top module, so it is not carried here.
interface slu_regfile_sync_if #(
  parameter int NUM_REGS = 16
) ();
  logic                    rw_n;
  logic                    strobe;
  logic [7:0]              address;
  logic [NUM_REGS*8-1:0]   memory;
  logic                    wr_pulse;
  logic                    busy;

  modport master (output rw_n, output strobe, output address,
                  input memory, input wr_pulse, input busy);
  modport slave  (input rw_n, input strobe, input address,
                  output memory, output wr_pulse, output busy);
endinterface

// File: rtl/slu_regfile_sync.sv
// SLU-bus register file: strobe synchronised into clk, one access per strobe rise (acts 3 clk after edge).
// No backpressure: the host holds the bus stable; busy only reports the relay settle timer.
module slu_regfile_sync #(
  parameter int         NUM_REGS      = 16,
  parameter logic [7:0] CARD_TYPE     = 8'h43,
  parameter logic [7:0] CARD_CONFIG   = 8'h0F,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  slu_regfile_sync_if.slave bus,
  inout  wire  [7:0]        data_bus
);
  localparam int RLY_W = (NUM_REGS - 6) * 8;

  logic [2:0]            r_stb_sync;
  logic                  r_wr_pulse;
  logic [7:0]            r_rd_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dce;
  logic [2:0]            r_ctl;
  logic [7:0]            r_abus;
  logic [7:0]            r_scratch;
  logic [RLY_W-1:0]      r_relay;

  logic                  w_stb_rise;
  logic                  w_in_range;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_load;
  logic                  w_oar;
  logic                  w_busy;
  logic [7:0]            w_rd_byte;
  logic [NUM_REGS*8-1:0] w_mem;

  assign w_stb_rise = r_stb_sync[1] & ~r_stb_sync[2];
  assign w_in_range = {1'b0, bus.address} < 9'(NUM_REGS);
  assign w_wr       = w_stb_rise & ~bus.rw_n & w_in_range;
  assign w_rd       = w_stb_rise & bus.rw_n;
  assign w_load     = w_wr & ((bus.address == 8'h02) | (bus.address == 8'h04) |
                              (bus.address >= 8'h06));
  // CHAIN_RST is treated as an OAR alias; both win over the rest of the byte.
  assign w_oar      = w_wr & (bus.address == 8'h02) & (data_bus[5] | data_bus[0]);
  assign w_busy     = (r_cnt != '0);

  // Abus high nibble is forced open until DCE is set; stored bits stay intact.
  always_comb begin
    w_mem                        = '0;
    w_mem[7:0]                   = CARD_TYPE;
    w_mem[15:8]                  = CARD_CONFIG;
    w_mem[23:16]                 = {~w_busy, r_dce, 2'b00, r_ctl, 1'b0};
    w_mem[31:24]                 = 8'h55;
    w_mem[39:32]                 = r_dce ? r_abus : (r_abus | 8'hF0);
    w_mem[47:40]                 = r_scratch;
    w_mem[NUM_REGS*8-1:48]       = r_relay;
  end

  always_comb begin
    w_rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(bus.address) == i) w_rd_byte = w_mem[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stb_sync <= '0;
      r_wr_pulse <= 1'b0;
      r_rd_data  <= 8'h00;
      r_cnt      <= '0;
      r_dce      <= 1'b0;
      r_ctl      <= 3'b000;
      r_abus     <= 8'hF0;
      r_scratch  <= 8'hAA;
      r_relay    <= '0;
    end else begin
      r_stb_sync <= {r_stb_sync[1:0], bus.strobe};
      r_wr_pulse <= w_wr;
      if (w_rd) r_rd_data <= w_rd_byte;

      if (w_load)      r_cnt <= CNT_W'(SETTLE_CYCLES);
      else if (w_busy) r_cnt <= r_cnt - CNT_W'(1);

      if (w_oar) begin
        r_dce   <= 1'b0;
        r_ctl   <= 3'b000;
        r_abus  <= 8'hF0;
        r_relay <= '0;
      end else if (w_wr) begin
        case (bus.address)
          8'h02: begin
            r_dce <= r_dce | data_bus[6];
            r_ctl <= data_bus[3:1];
          end
          8'h04: r_abus    <= data_bus;
          8'h05: r_scratch <= data_bus;
          default: begin
            for (int i = 6; i < NUM_REGS; i++) begin
              if (int'(bus.address) == i) r_relay[(i-6)*8 +: 8] <= data_bus;
            end
          end
        endcase
      end
    end
  end

  assign data_bus     = bus.rw_n ? r_rd_data : 8'hzz;
  assign bus.memory   = w_mem;
  assign bus.wr_pulse = r_wr_pulse;
  assign bus.busy     = w_busy;
endmodule

// File: tb/tb_slu_regfile_sync.sv
// Scoreboarded bench for slu_regfile_sync with a short settle time (8 clk).
module tb_slu_regfile_sync;
  localparam int NR = 16;

  logic       clk;
  logic       reset_n;
  wire  [7:0] data_bus;
  logic [7:0] tb_drv;
  logic       tb_drv_en;

  slu_regfile_sync_if #(.NUM_REGS(NR)) sif ();

  slu_regfile_sync #(
    .NUM_REGS(NR), .CARD_TYPE(8'h43), .CARD_CONFIG(8'h0F),
    .SETTLE_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(sif), .data_bus(data_bus)
  );

  assign data_bus = tb_drv_en ? tb_drv : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  // Event monitor, sampled just after each active edge.
  int   cyc = 0, wr_cnt = 0, busy_cyc = 0, wp_last = 0, wp_prev = 0, fall = 0;
  logic busy_q = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sif.wr_pulse) begin wr_cnt++; wp_prev = wp_last; wp_last = cyc; end
    if (sif.busy) busy_cyc++;
    if (busy_q && !sif.busy) fall = cyc;
    busy_q = sif.busy;
  end

  function automatic logic [7:0] byte_of(input int n);
    return sif.memory[n*8 +: 8];
  endfunction

  task automatic access(input logic [7:0] addr, input logic wr, input logic [7:0] wdat);
    @(negedge clk);
    sif.address = addr; sif.rw_n = ~wr; tb_drv = wdat; tb_drv_en = wr;
    @(negedge clk); sif.strobe = 1'b1;
    repeat (4) @(negedge clk);
    sif.strobe = 1'b0;
    @(negedge clk); sif.rw_n = 1'b1; tb_drv_en = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] wdat);
    access(addr, 1'b1, wdat);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    access(addr, 1'b0, 8'h00);
    e = exp_q.pop_front();
    n_chk++;
    if (data_bus !== e) begin
      n_fail++;
      $display("FAIL read[%02h]: got %02h expected %02h", addr, data_bus, e);
    end
  endtask

  task automatic chk_byte(input string nm, input int n, input logic [7:0] exp);
    n_chk++;
    if (byte_of(n) !== exp) begin
      n_fail++;
      $display("FAIL %s byte%0d: got %02h expected %02h", nm, n, byte_of(n), exp);
    end
  endtask

  task automatic test_reset;
    logic [7:0] rv [NR];
    for (int i = 0; i < NR; i++) rv[i] = 8'h00;
    rv[0] = 8'h43; rv[1] = 8'h0F; rv[2] = 8'h80; rv[3] = 8'h55; rv[4] = 8'hF0; rv[5] = 8'hAA;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (sif.busy !== 1'b0 || sif.wr_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b wr_pulse=%b expected 0/0", sif.busy, sif.wr_pulse);
    end
    for (int i = 0; i < NR; i++) chk_byte("reset_image", i, rv[i]);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(8'h00, 8'h43);
    do_read(8'h01, 8'h0F);
    do_read(8'h03, 8'h55);
    do_read(8'h05, 8'hAA);
    do_read(8'h02, 8'h80);
    do_read(8'h04, 8'hF0);
  endtask

  task automatic test_scratch;
    int w0 = wr_cnt;
    busy_cyc = 0;
    do_write(8'h05, 8'h83);
    do_read(8'h05, 8'h83);
    n_chk++;
    if (wr_cnt - w0 != 1 || busy_cyc != 0) begin
      n_fail++;
      $display("FAIL scratch_side: pulses=%0d busy_cycles=%0d expected 1/0", wr_cnt - w0, busy_cyc);
    end
  endtask

  task automatic test_settle;
    busy_cyc = 0;
    do_write(8'h06, 8'h5A);
    do_read(8'h02, 8'h00);
    repeat (10) @(negedge clk);
    n_chk++;
    if (busy_cyc != 8 || fall - wp_last != 8) begin
      n_fail++;
      $display("FAIL settle_len: busy_cycles=%0d fall_offset=%0d expected 8/8", busy_cyc, fall - wp_last);
    end
    do_read(8'h02, 8'h80);
  endtask

  task automatic test_back_to_back;
    busy_cyc = 0;
    do_write(8'h06, 8'h5A);
    do_write(8'h07, 8'hA5);
    repeat (14) @(negedge clk);
    n_chk++;
    if (wp_last - wp_prev >= 8 || busy_cyc != (wp_last - wp_prev) + 8 || fall - wp_last != 8) begin
      n_fail++;
      $display("FAIL settle_reload: busy_cycles=%0d gap=%0d fall_offset=%0d expected gap+8 and 8",
               busy_cyc, wp_last - wp_prev, fall - wp_last);
    end
    chk_byte("relay", 6, 8'h5A);
    chk_byte("relay", 7, 8'hA5);
  endtask

  task automatic test_dce;
    do_write(8'h04, 8'h03);
    chk_byte("abus_masked", 4, 8'hF3);
    do_write(8'h02, 8'h40);
    chk_byte("abus_dce", 4, 8'h03);
    repeat (10) @(negedge clk);
    chk_byte("status_dce", 2, 8'hC0);
    do_write(8'h02, 8'h0E);
    repeat (10) @(negedge clk);
    chk_byte("status_rly", 2, 8'hCE);
  endtask

  task automatic test_oar;
    do_write(8'h02, 8'h21);
    repeat (10) @(negedge clk);
    chk_byte("oar_status", 2, 8'h80);
    chk_byte("oar_abus", 4, 8'hF0);
    chk_byte("oar_relay", 6, 8'h00);
    chk_byte("oar_relay", 7, 8'h00);
    chk_byte("oar_scratch", 5, 8'h83);
  endtask

  task automatic test_out_of_range;
    logic [NR*8-1:0] snap;
    int w0 = wr_cnt;
    snap = sif.memory;
    busy_cyc = 0;
    do_write(8'h10, 8'h99);
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_cnt != w0 || busy_cyc != 0 || sif.memory !== snap) begin
      n_fail++;
      $display("FAIL oor_write: pulses=%0d busy_cycles=%0d image_changed=%b expected 0/0/0",
               wr_cnt - w0, busy_cyc, sif.memory !== snap);
    end
    do_read(8'h10, 8'h00);
    do_read(8'hFF, 8'h00);
  endtask

  task automatic test_reset_mid_busy;
    int w0;
    do_write(8'h06, 8'h77);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (sif.busy !== 1'b0 || sif.wr_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL midbusy_reset: busy=%b wr_pulse=%b expected 0/0", sif.busy, sif.wr_pulse);
    end
    chk_byte("midbusy_relay", 6, 8'h00);
    chk_byte("midbusy_scratch", 5, 8'hAA);
    chk_byte("midbusy_status", 2, 8'h80);
    // Strobe pulse entirely inside reset must be lost.
    w0 = wr_cnt;
    sif.address = 8'h05; sif.rw_n = 1'b0; tb_drv = 8'h11; tb_drv_en = 1'b1;
    sif.strobe = 1'b1;
    repeat (3) @(negedge clk);
    sif.strobe = 1'b0;
    repeat (3) @(negedge clk);
    sif.rw_n = 1'b1; tb_drv_en = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (wr_cnt != w0 || byte_of(5) !== 8'hAA) begin
      n_fail++;
      $display("FAIL strobe_in_reset: pulses=%0d byte5=%02h expected 0/aa", wr_cnt - w0, byte_of(5));
    end
  endtask

  initial begin
    reset_n = 1'b0; sif.strobe = 1'b0; sif.rw_n = 1'b1; sif.address = 8'h00;
    tb_drv = 8'h00; tb_drv_en = 1'b0;
    test_reset();
    test_scratch();
    test_settle();
    test_back_to_back();
    test_dce();
    test_oar();
    test_out_of_range();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
